// File: rtl/xs3_conv_sched_if.sv
// Request, converter and result signals shared between the
// two requesters, the excess-3 converter and the result consumer.
interface xs3_conv_sched_if #(
  parameter int NDIG = 4
);
  logic            req0_valid;
  logic [4*NDIG-1:0] req0_bcd;
  logic            req0_ready;
  logic            req1_valid;
  logic [4*NDIG-1:0] req1_bcd;
  logic            req1_ready;
  logic [3:0]      cnv_bcd;
  logic [3:0]      cnv_xs3;
  logic            res_valid;
  logic            res_ready;
  logic [4*NDIG-1:0] res_xs3;
  logic            res_id;
  logic            res_err;

  modport master (
    output req0_valid, req0_bcd,
    input  req0_ready,
    output req1_valid, req1_bcd,
    input  req1_ready,
    input  cnv_bcd,
    output cnv_xs3,
    input  res_valid,
    output res_ready,
    input  res_xs3, res_id, res_err
  );

  modport slave (
    input  req0_valid, req0_bcd,
    output req0_ready,
    input  req1_valid, req1_bcd,
    output req1_ready,
    output cnv_bcd,
    input  cnv_xs3,
    output res_valid,
    input  res_ready,
    output res_xs3, res_id, res_err
  );
endinterface

// File: rtl/xs3_conv_sched.sv
// Two-requester scheduler for a shared BCD-to-excess-3 converter,
// one digit per cycle, round-robin on contention.
module xs3_conv_sched #(
  parameter int NDIG = 4
) (
  input  logic clk,
  input  logic rst,
  xs3_conv_sched_if.slave bus
);
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [4*NDIG-1:0] cap;
  logic [4*NDIG-1:0] res;
  logic [CW-1:0]     cnt;
  logic              id;
  logic              last_id;
  logic              err;

  logic       g0;
  logic       g1;
  logic       rdy0;
  logic       rdy1;
  logic       rvld;
  logic [3:0] dig;
  logic [3:0] cbcd;

  // On contention the requester not served last time wins.
  assign g0 = bus.req0_valid &
              (~bus.req1_valid | last_id);
  assign g1 = bus.req1_valid &
              (~bus.req0_valid | ~last_id);

  assign dig = cap[{cnt, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    rvld     = 1'b0;
    cbcd     = 4'h0;
    unique case (state)
      IDLE: begin
        if (!rst) begin
          rdy0 = g0;
          rdy1 = g1;
          if (g0 | g1) state_nx = CONV;
        end
      end
      CONV: begin
        cbcd = dig;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        rvld = 1'b1;
        if (bus.res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap     <= '0;
      res     <= '0;
      cnt     <= '0;
      id      <= 1'b0;
      last_id <= 1'b1;
      err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (g0 | g1) begin
            cap     <= g0 ? bus.req0_bcd
                          : bus.req1_bcd;
            id      <= g1;
            last_id <= g1;
            cnt     <= '0;
            err     <= 1'b0;
          end
        end
        CONV: begin
          if (dig > 4'd9) begin
            err <= 1'b1;
            res[{cnt, 2'b00} +: 4] <= 4'h0;
          end else begin
            res[{cnt, 2'b00} +: 4] <= bus.cnv_xs3;
          end
          cnt <= (cnt == LAST) ? '0
                               : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.cnv_bcd    = cbcd;
  assign bus.res_valid  = rvld;
  assign bus.res_xs3    = res;
  assign bus.res_id     = id;
  assign bus.res_err    = err;
endmodule

// File: tb/tb_xs3_conv_sched.sv
// Directed and randomized checks of xs3_conv_sched against a
// digit-level excess-3 model and a round-robin arbitration model.
module tb_xs3_conv_sched;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mlast = 1'b1;

  xs3_conv_sched_if #(.NDIG(N)) bus ();

  xs3_conv_sched #(.NDIG(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.cnv_xs3 = bus.cnv_bcd + 4'd3;

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic void xs3_ref(
      input  logic [4*N-1:0] bcd,
      output logic [4*N-1:0] xs3,
      output bit             err);
    int d;
    xs3 = '0;
    err = 1'b0;
    for (int i = 0; i < N; i++) begin
      d = int'((bcd >> (4 * i)) & 'hF);
      if (d > 9) err = 1'b1;
      else xs3 = xs3 | ((4*N)'(d + 3) << (4 * i));
    end
  endfunction

  function automatic logic [4*N-1:0] rnd_bcd();
    logic [4*N-1:0] v = '0;
    for (int i = 0; i < N; i++)
      v = v | ((4*N)'($urandom_range(0, 11)) << (4 * i));
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_rdy0", bus.req0_ready, 0);
    chk("rst_rdy1", bus.req1_ready, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_rvld", bus.res_valid, 0);
    chk("rst_cnv", bus.cnv_bcd, 0);
    chk("rst_xs3", bus.res_xs3, 0);
    chk("rst_id", bus.res_id, 0);
    chk("rst_err", bus.res_err, 0);
    rst = 1'b0;
    mlast = 1'b1;
  endtask

  // Serve one request starting from an IDLE cycle.
  task automatic serve(input int hold, input bit raise0);
    bit w;
    bit ee;
    logic [4*N-1:0] cap;
    logic [4*N-1:0] ex;
    logic [4*N-1:0] dsh;
    if (bus.req0_valid && bus.req1_valid) w = ~mlast;
    else w = bus.req1_valid;
    #1;
    chk("grant0", bus.req0_ready, 32'(!w));
    chk("grant1", bus.req1_ready, 32'(w));
    cap = w ? bus.req1_bcd : bus.req0_bcd;
    xs3_ref(cap, ex, ee);
    @(negedge clk);
    mlast = w;
    if (w) bus.req1_valid = 1'b0;
    else   bus.req0_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      #1;
      dsh = cap >> (4 * i);
      chk("cnv_bcd", bus.cnv_bcd, 32'(dsh[3:0]));
      chk("conv_rvld", bus.res_valid, 0);
      @(negedge clk);
    end
    for (int h = 0; h < hold; h++) begin
      #1;
      chk("hold_rvld", bus.res_valid, 1);
      chk("hold_xs3", bus.res_xs3, 32'(ex));
      chk("hold_id", bus.res_id, 32'(w));
      chk("hold_err", bus.res_err, 32'(ee));
      chk("hold_rdy0", bus.req0_ready, 0);
      chk("hold_rdy1", bus.req1_ready, 0);
      chk("hold_cnv", bus.cnv_bcd, 0);
      @(negedge clk);
    end
    #1;
    chk("res_valid", bus.res_valid, 1);
    chk("res_xs3", bus.res_xs3, 32'(ex));
    chk("res_id", bus.res_id, 32'(w));
    chk("res_err", bus.res_err, 32'(ee));
    if (raise0) begin
      bus.req0_valid = 1'b1;
      bus.req0_bcd   = rnd_bcd();
    end
    bus.res_ready = 1'b1;
    #1;
    chk("hs_rdy0", bus.req0_ready, 0);
    chk("hs_rdy1", bus.req1_ready, 0);
    @(negedge clk);
    bus.res_ready = 1'b0;
    #1;
    chk("post_rvld", bus.res_valid, 0);
  endtask

  initial begin
    bus.req0_valid = 1'b1;
    bus.req0_bcd   = '0;
    bus.req1_valid = 1'b1;
    bus.req1_bcd   = '0;
    bus.res_ready  = 1'b0;
    @(negedge clk);
    do_reset();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Single requester, known vector.
    bus.req0_valid = 1'b1;
    bus.req0_bcd   = 16'h1234;
    serve(0, 1'b0);
    chk("vec1234", bus.res_xs3, 32'h4567);

    // Contention right after reset: req0, req1, then req0.
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_bcd   = 16'h0000;
    bus.req1_valid = 1'b1;
    bus.req1_bcd   = 16'h9999;
    serve(0, 1'b1);
    bus.req0_bcd = 16'h0000;
    serve(0, 1'b1);
    bus.req1_valid = 1'b1;
    bus.req1_bcd   = rnd_bcd();
    serve(0, 1'b0);
    bus.req1_valid = 1'b0;
    @(negedge clk);

    // Invalid digit.
    bus.req1_valid = 1'b1;
    bus.req1_bcd   = 16'h12A4;
    serve(0, 1'b0);
    chk("vec12A4", bus.res_xs3, 32'h4507);
    chk("err12A4", bus.res_err, 1);

    // Stalled consumer with the other requester waiting,
    // and req0 raised during the handshake.
    bus.req0_valid = 1'b1;
    bus.req0_bcd   = rnd_bcd();
    bus.req1_valid = 1'b1;
    bus.req1_bcd   = rnd_bcd();
    serve(5, 1'b0);
    serve(0, 1'b1);
    serve(0, 1'b0);

    // Reset during the second conversion cycle.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_bcd   = rnd_bcd();
    bus.req1_bcd   = rnd_bcd();
    #1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mlast = 1'b1;
    #1;
    chk("abort_rvld", bus.res_valid, 0);
    chk("abort_cnv", bus.cnv_bcd, 0);
    chk("abort_rdy0", bus.req0_ready, 1);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    serve(0, 1'b0);
    serve(1, 1'b0);

    // Randomized traffic.
    for (int k = 0; k < 30; k++) begin
      if (!bus.req0_valid && !bus.req1_valid) begin
        if ($urandom_range(0, 1) == 0) begin
          bus.req0_valid = 1'b1;
          bus.req0_bcd   = rnd_bcd();
        end else begin
          bus.req1_valid = 1'b1;
          bus.req1_bcd   = rnd_bcd();
        end
      end
      if (!bus.req0_valid && $urandom_range(0, 1) == 1) begin
        bus.req0_valid = 1'b1;
        bus.req0_bcd   = rnd_bcd();
      end
      if (!bus.req1_valid && $urandom_range(0, 1) == 1) begin
        bus.req1_valid = 1'b1;
        bus.req1_bcd   = rnd_bcd();
      end
      serve(int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
